// File: rtl/slc3_ctrl_if.sv
// slc3_ctrl_if: control/status bundle between the SLC-3 control FSM and its datapath
interface slc3_ctrl_if;
    logic        run_i;
    logic        continue_i;
    logic [15:0] ir;
    logic        ben;
    logic        ld_mar, ld_mdr, ld_ir, ld_pc, ld_ben, ld_cc, ld_reg, ld_led;
    logic        gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0]  pcmux;
    logic        drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0]  addr2mux;
    logic [1:0]  aluk;
    logic        mem_mem_ena, mem_wr_ena, halted_o;
    modport master (
        input  run_i, continue_i, ir, ben,
        output ld_mar, ld_mdr, ld_ir, ld_pc, ld_ben, ld_cc, ld_reg, ld_led,
        output gate_pc, gate_mdr, gate_alu, gate_marmux,
        output pcmux, drmux, sr1mux, sr2mux, addr1mux, addr2mux, aluk,
        output mem_mem_ena, mem_wr_ena, halted_o
    );
    modport slave (
        output run_i, continue_i, ir, ben,
        input  ld_mar, ld_mdr, ld_ir, ld_pc, ld_ben, ld_cc, ld_reg, ld_led,
        input  gate_pc, gate_mdr, gate_alu, gate_marmux,
        input  pcmux, drmux, sr1mux, sr2mux, addr1mux, addr2mux, aluk,
        input  mem_mem_ena, mem_wr_ena, halted_o
    );
endinterface

// File: rtl/slc3_ctrl_fsm.sv
// slc3_ctrl_fsm: fetch/decode/execute sequencer for the SLC-3 datapath
module slc3_ctrl_fsm #(
    parameter int unsigned MEM_WAIT = 3
) (
    input logic          clk,
    input logic          reset,
    slc3_ctrl_if.master  b
);
    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32, S1, S5, S9, S0, S22, S12,
        S4, S21, S6, S7, S25, S27, S23, S16, P1, P2
    } state_t;

    state_t     st, nx;
    logic [2:0] cnt, cnt_nx;
    logic       last;

    assign last = (cnt == 3'(MEM_WAIT - 1));

    // state and wait counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st  <= HALTED;
            cnt <= 3'd0;
        end else begin
            st  <= nx;
            cnt <= cnt_nx;
        end
    end

    // next state, counter and Moore control outputs
    always_comb begin
        nx            = st;
        cnt_nx        = 3'd0;
        b.ld_mar      = 1'b0;
        b.ld_mdr      = 1'b0;
        b.ld_ir       = 1'b0;
        b.ld_pc       = 1'b0;
        b.ld_ben      = 1'b0;
        b.ld_cc       = 1'b0;
        b.ld_reg      = 1'b0;
        b.ld_led      = 1'b0;
        b.gate_pc     = 1'b0;
        b.gate_mdr    = 1'b0;
        b.gate_alu    = 1'b0;
        b.gate_marmux = 1'b0;
        b.pcmux       = 2'b00;
        b.drmux       = 1'b0;
        b.sr1mux      = 1'b0;
        b.sr2mux      = 1'b0;
        b.addr1mux    = 1'b0;
        b.addr2mux    = 2'b00;
        b.aluk        = 2'b00;
        b.mem_mem_ena = 1'b0;
        b.mem_wr_ena  = 1'b0;
        b.halted_o    = 1'b0;
        case (st)
            HALTED: begin
                b.halted_o = 1'b1;
                nx = b.run_i ? S18 : HALTED;
            end
            S18: begin
                b.gate_pc = 1'b1;
                b.ld_mar  = 1'b1;
                b.ld_pc   = 1'b1;
                nx = S33;
            end
            S33, S25: begin
                b.mem_mem_ena = 1'b1;
                b.ld_mdr      = last;
                cnt_nx = last ? 3'd0 : cnt + 3'd1;
                nx = !last ? st : (st == S33) ? S35 : S27;
            end
            S35: begin
                b.gate_mdr = 1'b1;
                b.ld_ir    = 1'b1;
                nx = S32;
            end
            S32: begin
                b.ld_ben = 1'b1;
                case (b.ir[15:12])
                    4'b0001: nx = S1;
                    4'b0101: nx = S5;
                    4'b1001: nx = S9;
                    4'b0000: nx = S0;
                    4'b1100: nx = S12;
                    4'b0100: nx = S4;
                    4'b0110: nx = S6;
                    4'b0111: nx = S7;
                    4'b1101: nx = P1;
                    default: nx = S18;
                endcase
            end
            S1, S5, S9: begin
                b.gate_alu = 1'b1;
                b.ld_reg   = 1'b1;
                b.ld_cc    = 1'b1;
                b.sr1mux   = 1'b1;
                b.sr2mux   = (st != S9) && b.ir[5];
                b.aluk     = (st == S5) ? 2'b01 : (st == S9) ? 2'b10 : 2'b00;
                nx = S18;
            end
            S0: nx = b.ben ? S22 : S18;
            S22: begin
                b.addr2mux = 2'b10;
                b.pcmux    = 2'b10;
                b.ld_pc    = 1'b1;
                nx = S18;
            end
            S12: begin
                b.sr1mux   = 1'b1;
                b.addr1mux = 1'b1;
                b.pcmux    = 2'b10;
                b.ld_pc    = 1'b1;
                nx = S18;
            end
            S4: begin
                b.gate_pc = 1'b1;
                b.drmux   = 1'b1;
                b.ld_reg  = 1'b1;
                nx = S21;
            end
            S21: begin
                b.addr2mux = 2'b11;
                b.pcmux    = 2'b10;
                b.ld_pc    = 1'b1;
                nx = S18;
            end
            S6, S7: begin
                b.gate_marmux = 1'b1;
                b.sr1mux      = 1'b1;
                b.addr1mux    = 1'b1;
                b.addr2mux    = 2'b01;
                b.ld_mar      = 1'b1;
                nx = (st == S6) ? S25 : S23;
            end
            S27: begin
                b.gate_mdr = 1'b1;
                b.ld_reg   = 1'b1;
                b.ld_cc    = 1'b1;
                nx = S18;
            end
            S23: begin
                b.aluk     = 2'b11;
                b.gate_alu = 1'b1;
                b.ld_mdr   = 1'b1;
                nx = S16;
            end
            S16: begin
                b.mem_mem_ena = 1'b1;
                b.mem_wr_ena  = 1'b1;
                cnt_nx = last ? 3'd0 : cnt + 3'd1;
                nx = last ? S18 : S16;
            end
            // counter doubles as a "not first cycle" flag while paused
            P1: begin
                b.ld_led = (cnt == 3'd0);
                cnt_nx = b.continue_i ? 3'd0 : 3'd1;
                nx = b.continue_i ? P2 : P1;
            end
            P2: nx = b.continue_i ? P2 : S18;
            default: nx = HALTED;
        endcase
    end
endmodule

// File: tb/tb_slc3_ctrl_fsm.sv
// tb_slc3_ctrl_fsm: directed checks of the SLC-3 control sequencer
module tb_slc3_ctrl_fsm;
    localparam logic [24:0] LMAR = 25'(1) << 24, LMDR = 25'(1) << 23, LIR  = 25'(1) << 22,
                            LPC  = 25'(1) << 21, LBEN = 25'(1) << 20, LCC  = 25'(1) << 19,
                            LREG = 25'(1) << 18, LLED = 25'(1) << 17, GPC  = 25'(1) << 16,
                            GMDR = 25'(1) << 15, GALU = 25'(1) << 14, GMM  = 25'(1) << 13,
                            PCADD = 25'(2) << 11, SR1 = 25'(1) << 9, SR2 = 25'(1) << 8,
                            A1 = 25'(1) << 7, A2_6 = 25'(1) << 5, A2_9 = 25'(2) << 5,
                            APASS = 25'(3) << 3, MEN = 25'(1) << 2, WEN = 25'(1) << 1,
                            HLT = 25'(1);
    localparam logic [24:0] FETCH = GPC | LMAR | LPC;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    slc3_ctrl_if b0 ();
    slc3_ctrl_if b1 ();

    slc3_ctrl_fsm #(.MEM_WAIT(3)) dut  (.clk(clk), .reset(reset), .b(b0));
    slc3_ctrl_fsm #(.MEM_WAIT(1)) dut1 (.clk(clk), .reset(reset), .b(b1));

    always #5 clk = ~clk;

    logic [24:0] ov0, ov1;
    assign ov0 = {b0.ld_mar, b0.ld_mdr, b0.ld_ir, b0.ld_pc, b0.ld_ben, b0.ld_cc, b0.ld_reg,
                  b0.ld_led, b0.gate_pc, b0.gate_mdr, b0.gate_alu, b0.gate_marmux, b0.pcmux,
                  b0.drmux, b0.sr1mux, b0.sr2mux, b0.addr1mux, b0.addr2mux, b0.aluk,
                  b0.mem_mem_ena, b0.mem_wr_ena, b0.halted_o};
    assign ov1 = {b1.ld_mar, b1.ld_mdr, b1.ld_ir, b1.ld_pc, b1.ld_ben, b1.ld_cc, b1.ld_reg,
                  b1.ld_led, b1.gate_pc, b1.gate_mdr, b1.gate_alu, b1.gate_marmux, b1.pcmux,
                  b1.drmux, b1.sr1mux, b1.sr2mux, b1.addr1mux, b1.addr2mux, b1.aluk,
                  b1.mem_mem_ena, b1.mem_wr_ena, b1.halted_o};

    task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // from S18: three read cycles, S35, then land in S32
    task automatic fetch(input string tag);
        step();
        chk({tag, "_s33a"}, ov0, MEN);
        step();
        step();
        chk({tag, "_s33last"}, ov0, MEN | LMDR);
        step();
        chk({tag, "_s35"}, ov0, GMDR | LIR);
        step();
        chk({tag, "_s32"}, ov0, LBEN);
    endtask

    initial begin
        b0.run_i = 1'b0; b0.continue_i = 1'b0; b0.ir = 16'h0000; b0.ben = 1'b0;
        b1.run_i = 1'b0; b1.continue_i = 1'b0; b1.ir = 16'h0000; b1.ben = 1'b0;
        #12;
        chk("reset_halted", ov0, HLT);
        reset = 1'b1;
        step();
        chk("idle_halted", ov0, HLT);
        // ADD R1,R1,#1
        b0.ir = 16'h1261;
        b0.run_i = 1'b1;
        step();
        b0.run_i = 1'b0;
        chk("add_c1_s18", ov0, FETCH);
        fetch("add");
        step();
        chk("add_c7_exec", ov0, GALU | LREG | LCC | SR1 | SR2);
        step();
        chk("add_c8_s18", ov0, FETCH);
        // BRz taken
        b0.ir = 16'h0402;
        b0.ben = 1'b1;
        fetch("brt");
        step();
        chk("brt_s0", ov0, 25'd0);
        step();
        chk("brt_s22", ov0, LPC | PCADD | A2_9);
        step();
        chk("brt_s18", ov0, FETCH);
        // BRz not taken
        b0.ben = 1'b0;
        fetch("brn");
        step();
        chk("brn_s0", ov0, 25'd0);
        step();
        chk("brn_s18", ov0, FETCH);
        // STR
        b0.ir = 16'h7042;
        fetch("str");
        step();
        chk("str_s7", ov0, GMM | SR1 | A1 | A2_6 | LMAR);
        step();
        chk("str_s23", ov0, APASS | GALU | LMDR);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("str_s16", ov0, MEN | WEN);
        end
        step();
        chk("str_s18", ov0, FETCH);
        // PAUSE
        b0.ir = 16'hD000;
        fetch("pause");
        step();
        chk("pause_led", ov0, LLED);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_p1_hold", ov0, 25'd0);
        end
        b0.continue_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pause_p2_hold", ov0, 25'd0);
        end
        b0.continue_i = 1'b0;
        step();
        chk("pause_s18", ov0, FETCH);
        // illegal opcode acts as NOP
        b0.ir = 16'h8000;
        fetch("nop");
        step();
        chk("nop_s18", ov0, FETCH);
        // reset mid-read
        step();
        step();
        chk("mid_s33", ov0, MEN);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", ov0, HLT);
        step();
        chk("reset_edge_halted", ov0, HLT);
        reset = 1'b1;
        step();
        chk("post_reset_halted", ov0, HLT);
        // single-cycle read
        b1.run_i = 1'b1;
        step();
        b1.run_i = 1'b0;
        chk("mw1_s18", ov1, FETCH);
        step();
        chk("mw1_s33", ov1, MEN | LMDR);
        step();
        chk("mw1_s35", ov1, GMDR | LIR);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
